vga_timing_gen: RTL and testbench

//  Free-running VGA raster timing generator. Produces H/V sync, pixel position, line/frame strobes and the

---
 rtl/vga_timing_gen_pkg.sv | 29 ++
 rtl/vga_timing_gen_axis_counter.sv | 86 ++++++++
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_pkg
// Purpose  : Default 640x480@60 timing constants, position width and the
//            per-axis phase encoding.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_gen_pkg;

    localparam int c_POS_W = 10;

    localparam int c_H_VIS  = 640;
    localparam int c_H_FP   = 16;
    localparam int c_H_SYNC = 96;
    localparam int c_H_BP   = 48;
    localparam int c_V_VIS  = 480;
    localparam int c_V_FP   = 10;
    localparam int c_V_SYNC = 2;
    localparam int c_V_BP   = 33;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Purpose  : One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK
//            phase FSM, stepping only when advance is high.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int VIS  = c_H_VIS,
    parameter int FP   = c_H_FP,
    parameter int SYNC = c_H_SYNC,
    parameter int BP   = c_H_BP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    output logic [c_POS_W-1:0] pos,
    output phase_t             phase,
    output logic               at_max
);

    localparam int TOT = VIS + FP + SYNC + BP;
    localparam logic [c_POS_W-1:0] c_POS_MAX = c_POS_W'(TOT - 1);

    phase_t             r_phase;
    phase_t             w_phase_nxt;
    logic [c_POS_W-1:0] r_pos;
    logic [c_POS_W-1:0] w_pos_nxt;
    logic [c_POS_W-1:0] r_cnt;
    logic [c_POS_W-1:0] w_cnt_nxt;
    logic [c_POS_W-1:0] w_len_m1;
    logic               r_at_max;

    always_comb begin
        w_len_m1 = c_POS_W'(VIS - 1);
        case (r_phase)
            PH_FRONT: w_len_m1 = c_POS_W'(FP - 1);
            PH_SYNC:  w_len_m1 = c_POS_W'(SYNC - 1);
            PH_BACK:  w_len_m1 = c_POS_W'(BP - 1);
            default:  w_len_m1 = c_POS_W'(VIS - 1);
        endcase
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = r_pos;
        if (advance) begin
            w_pos_nxt = (r_pos == c_POS_MAX) ? '0 : r_pos + 1'b1;
            if (r_cnt == w_len_m1) begin
                w_cnt_nxt = '0;
                case (r_phase)
                    PH_ACTIVE: w_phase_nxt = PH_FRONT;
                    PH_FRONT:  w_phase_nxt = PH_SYNC;
                    PH_SYNC:   w_phase_nxt = PH_BACK;
                    default:   w_phase_nxt = PH_ACTIVE;
                endcase
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase  <= PH_ACTIVE;
            r_cnt    <= '0;
            r_pos    <= '0;
            r_at_max <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pos    <= w_pos_nxt;
            r_at_max <= (w_pos_nxt == c_POS_MAX);
        end
    end

    // phase is the next-state value so the top's registered decodes line up with pos
    assign pos    = r_pos;
    assign phase  = w_phase_nxt;
    assign at_max = r_at_max;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Free-running VGA raster timing generator (sync, position, strobes,
//            visible flag). Define VGA_TIMING_FRAME_CTR_EN to add frame[7:0].
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_VIS    = c_H_VIS,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_VIS    = c_V_VIS,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic [c_POS_W-1:0] hpos,
    output logic [c_POS_W-1:0] vpos,
    output logic               hmax,
    output logic               vmax,
`ifdef VGA_TIMING_FRAME_CTR_EN
    output logic [7:0]         frame,
`endif
    output logic               visible
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [c_POS_W-1:0] c_H_PRE = c_POS_W'(H_TOT - 2);

    generate
        if (H_TOT > 1024 || V_TOT > 1024 || H_VIS == 0 || H_FP == 0 || H_SYNC == 0 ||
            H_BP == 0 || V_VIS == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
            $error("vga_timing_gen: timing parameters out of range");
        end
    endgenerate

    logic [c_POS_W-1:0] w_hpos;
    logic [c_POS_W-1:0] w_vpos;
    phase_t             w_h_phase_nxt;
    phase_t             w_v_phase_nxt;
    logic               w_h_at_max;
    logic               w_v_at_max;

    logic r_hsync;
    logic r_vsync;
    logic r_visible;
    logic r_vmax;

    vga_axis_counter #(
        .VIS  (H_VIS),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .advance (1'b1),
        .pos     (w_hpos),
        .phase   (w_h_phase_nxt),
        .at_max  (w_h_at_max)
    );

    vga_axis_counter #(
        .VIS  (V_VIS),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .advance (w_h_at_max),
        .pos     (w_vpos),
        .phase   (w_v_phase_nxt),
        .at_max  (w_v_at_max)
    );

    // vpos cannot move on the cycle before hmax, so its current at_max is also its next one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync   <= ~SYNC_POL;
            r_vsync   <= ~SYNC_POL;
            r_visible <= 1'b1;
            r_vmax    <= 1'b0;
        end else begin
            r_hsync   <= (w_h_phase_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync   <= (w_v_phase_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_visible <= (w_h_phase_nxt == PH_ACTIVE) && (w_v_phase_nxt == PH_ACTIVE);
            r_vmax    <= (w_hpos == c_H_PRE) && w_v_at_max;
        end
    end

`ifdef VGA_TIMING_FRAME_CTR_EN
    logic [7:0] r_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame <= 8'd0;
        end else if (r_vmax) begin
            r_frame <= r_frame + 8'd1;
        end
    end

    assign frame = r_frame;
`endif

    assign hsync   = r_hsync;
    assign vsync   = r_vsync;
    assign hpos    = w_hpos;
    assign vpos    = w_vpos;
    assign hmax    = w_h_at_max;
    assign vmax    = r_vmax;
    assign visible = r_visible;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Directed self-checking bench for vga_timing_gen (default, reduced
//            active-low and tiny configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def  = 1'b1;
    logic rst_alt  = 1'b1;
    logic rst_tiny = 1'b1;

    logic       d_hsync, d_vsync, d_hmax, d_vmax, d_visible;
    logic [9:0] d_hpos, d_vpos;
    logic       a_hsync, a_vsync, a_hmax, a_vmax, a_visible;
    logic [9:0] a_hpos, a_vpos;
    logic       t_hsync, t_vsync, t_hmax, t_vmax, t_visible;
    logic [9:0] t_hpos, t_vpos;
`ifdef VGA_TIMING_FRAME_CTR_EN
    logic [7:0] d_frame, a_frame, t_frame;
`endif

    int n_pass  = 0;
    int n_total = 0;

    vga_timing_gen u_def (
        .clk(clk), .reset(rst_def), .hsync(d_hsync), .vsync(d_vsync),
        .hpos(d_hpos), .vpos(d_vpos), .hmax(d_hmax), .vmax(d_vmax),
`ifdef VGA_TIMING_FRAME_CTR_EN
        .frame(d_frame),
`endif
        .visible(d_visible)
    );

    vga_timing_gen #(
        .H_VIS(320), .H_FP(8), .H_SYNC(16), .H_BP(23),
        .V_VIS(4), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
    ) u_alt (
        .clk(clk), .reset(rst_alt), .hsync(a_hsync), .vsync(a_vsync),
        .hpos(a_hpos), .vpos(a_vpos), .hmax(a_hmax), .vmax(a_vmax),
`ifdef VGA_TIMING_FRAME_CTR_EN
        .frame(a_frame),
`endif
        .visible(a_visible)
    );

    vga_timing_gen #(
        .H_VIS(1), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_VIS(1), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) u_tiny (
        .clk(clk), .reset(rst_tiny), .hsync(t_hsync), .vsync(t_vsync),
        .hpos(t_hpos), .vpos(t_vpos), .hmax(t_hmax), .vmax(t_vmax),
`ifdef VGA_TIMING_FRAME_CTR_EN
        .frame(t_frame),
`endif
        .visible(t_visible)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_def = 1'b1;
        step();
        step();
        n_total++; if (d_hpos !== 10'd0)  $display("FAIL reset_hpos: got %0d want 0", d_hpos);  else n_pass++;
        n_total++; if (d_vpos !== 10'd0)  $display("FAIL reset_vpos: got %0d want 0", d_vpos);  else n_pass++;
        n_total++; if (d_hsync !== 1'b0)  $display("FAIL reset_hsync: got %b want 0", d_hsync); else n_pass++;
        n_total++; if (d_vsync !== 1'b0)  $display("FAIL reset_vsync: got %b want 0", d_vsync); else n_pass++;
        n_total++; if (d_hmax !== 1'b0)   $display("FAIL reset_hmax: got %b want 0", d_hmax);   else n_pass++;
        n_total++; if (d_vmax !== 1'b0)   $display("FAIL reset_vmax: got %b want 0", d_vmax);   else n_pass++;
        n_total++; if (d_visible !== 1'b1) $display("FAIL reset_visible: got %b want 1", d_visible); else n_pass++;
    endtask

    // Line 0 of the default mode, one column into line 1, then reset inside hsync.
    task automatic test_line0();
        int bad = -1;
        int hs_cnt = 0;
        logic [24:0] got, want, bad_got, bad_want;
        rst_def = 1'b0;
        for (int i = 0; i <= 800; i++) begin
            int h = i % 800;
            int v = i / 800;
            got  = {d_hpos, d_vpos, d_hmax, d_vmax, d_visible, d_hsync, d_vsync};
            want = {10'(h), 10'(v), (h == 799), 1'b0, (h < 640), (h >= 656 && h < 752), 1'b0};
            if (got !== want && bad < 0) begin
                bad = i; bad_got = got; bad_want = want;
            end
            if (i < 800 && d_hsync === 1'b1) hs_cnt++;
            if (i < 800) step();
        end
        n_total++;
        if (bad >= 0)
            $display("FAIL line0_raster cycle %0d: got h=%0d v=%0d flags=%b want h=%0d v=%0d flags=%b",
                     bad, bad_got[24:15], bad_got[14:5], bad_got[4:0], bad_want[24:15], bad_want[14:5], bad_want[4:0]);
        else n_pass++;
        n_total++; if (hs_cnt !== 96) $display("FAIL line0_hsync_width: got %0d want 96", hs_cnt); else n_pass++;
        n_total++;
        if (d_hpos !== 10'd0 || d_vpos !== 10'd1) $display("FAIL line_wrap: got (%0d,%0d) want (0,1)", d_hpos, d_vpos);
        else n_pass++;

        repeat (700) step();
        n_total++;
        if (d_hsync !== 1'b1 || d_hpos !== 10'd700) $display("FAIL def_pre_reset: got h=%0d hsync=%b want h=700 hsync=1", d_hpos, d_hsync);
        else n_pass++;
        rst_def = 1'b1;
        step();
        rst_def = 1'b0;
        n_total++;
        if ({d_hpos, d_vpos, d_hsync, d_vsync, d_visible} !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL def_midline_reset: got h=%0d v=%0d hs=%b vs=%b vis=%b want 0 0 0 0 1",
                     d_hpos, d_vpos, d_hsync, d_vsync, d_visible);
        else n_pass++;
        step();
        n_total++; if (d_hpos !== 10'd1) $display("FAIL def_after_reset_hpos: got %0d want 1", d_hpos); else n_pass++;
    endtask

    // Reduced active-low mode: 367 clocks per line, 11 lines per frame.
    task automatic test_alt_frame();
        int bad = -1;
        int hs_low = 0;
        int vs_low = 0;
        int vmax_cnt = 0;
        logic [24:0] got, want, bad_got, bad_want;
        rst_alt = 1'b1;
        step();
        rst_alt = 1'b0;
        for (int i = 0; i <= 4037; i++) begin
            int h = i % 367;
            int v = (i / 367) % 11;
            got  = {a_hpos, a_vpos, a_hmax, a_vmax, a_visible, a_hsync, a_vsync};
            want = {10'(h), 10'(v), (h == 366), (h == 366 && v == 10), (h < 320 && v < 4),
                    !(h >= 328 && h < 344), !(v >= 6 && v < 8)};
            if (got !== want && bad < 0) begin
                bad = i; bad_got = got; bad_want = want;
            end
            if (i < 367 && a_hsync === 1'b0) hs_low++;
            if (i < 4037 && a_vsync === 1'b0) vs_low++;
            if (i < 4037 && a_vmax === 1'b1) vmax_cnt++;
            if (i < 4037) step();
        end
        n_total++;
        if (bad >= 0)
            $display("FAIL alt_raster cycle %0d: got h=%0d v=%0d flags=%b want h=%0d v=%0d flags=%b",
                     bad, bad_got[24:15], bad_got[14:5], bad_got[4:0], bad_want[24:15], bad_want[14:5], bad_want[4:0]);
        else n_pass++;
        n_total++; if (hs_low !== 16)   $display("FAIL alt_hsync_width: got %0d want 16", hs_low);   else n_pass++;
        n_total++; if (vs_low !== 734)  $display("FAIL alt_vsync_width: got %0d want 734", vs_low);  else n_pass++;
        n_total++; if (vmax_cnt !== 1)  $display("FAIL alt_vmax_count: got %0d want 1", vmax_cnt);   else n_pass++;
    endtask

    // Reset asserted for one clock while both syncs are active.
    task automatic test_reset_mid_sync();
        rst_alt = 1'b1;
        step();
        rst_alt = 1'b0;
        repeat (6 * 367 + 330) step();
        n_total++;
        if ({a_hpos, a_vpos, a_hsync, a_vsync} !== {10'd330, 10'd6, 1'b0, 1'b0})
            $display("FAIL alt_pre_reset: got h=%0d v=%0d hs=%b vs=%b want 330 6 0 0", a_hpos, a_vpos, a_hsync, a_vsync);
        else n_pass++;
        rst_alt = 1'b1;
        step();
        rst_alt = 1'b0;
        n_total++;
        if ({a_hpos, a_vpos} !== {10'd0, 10'd0}) $display("FAIL midsync_pos: got (%0d,%0d) want (0,0)", a_hpos, a_vpos);
        else n_pass++;
        n_total++;
        if ({a_hsync, a_vsync, a_visible, a_hmax, a_vmax} !== 5'b11100)
            $display("FAIL midsync_flags: got hs/vs/vis/hmax/vmax=%b want 11100", {a_hsync, a_vsync, a_visible, a_hmax, a_vmax});
        else n_pass++;
        step();
        n_total++; if (a_hpos !== 10'd1) $display("FAIL midsync_next_hpos: got %0d want 1", a_hpos); else n_pass++;
    endtask

    // Tiny 4x4 raster: vmax period and, when present, the frame counter over 257 frames.
    task automatic test_tiny();
        int bad_vm = -1;
        logic got_vm;
`ifdef VGA_TIMING_FRAME_CTR_EN
        int bad_fr = -1;
        logic [7:0] got_fr, want_fr;
`endif
        rst_tiny = 1'b1;
        step();
        rst_tiny = 1'b0;
        for (int i = 0; i < 16 * 258; i++) begin
            if (t_vmax !== ((i % 16) == 15) && bad_vm < 0) begin
                bad_vm = i; got_vm = t_vmax;
            end
`ifdef VGA_TIMING_FRAME_CTR_EN
            if (t_frame !== 8'((i / 16) % 256) && bad_fr < 0) begin
                bad_fr = i; got_fr = t_frame; want_fr = 8'((i / 16) % 256);
            end
`endif
            step();
        end
        n_total++;
        if (bad_vm >= 0) $display("FAIL tiny_vmax cycle %0d: got %b want %b", bad_vm, got_vm, ~got_vm);
        else n_pass++;
`ifdef VGA_TIMING_FRAME_CTR_EN
        n_total++;
        if (bad_fr >= 0) $display("FAIL frame_count cycle %0d: got %0d want %0d", bad_fr, got_fr, want_fr);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_line0();
        test_alt_frame();
        test_reset_mid_sync();
        test_tiny();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
